// File: rtl/pipe_ctrl_if.sv
//------------------------------------------------------------------------------
// pipe_ctrl_if : hazard/event inputs and control outputs of the pipeline
//                control unit, grouped for connection to pipe_ctrl.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_ctrl_if;
  logic        id_loadstall_i;
  logic        id_inst_invalid_i;
  logic        id_pc_invalid_i;
  logic        id_wfi_i;
  logic [31:0] id_pc_i;
  logic        ex_branch_i;
  logic [31:0] ex_target_i;
  logic        mem_busy_i;
  logic        irq_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] epc_o;
  logic [1:0]  cause_o;
  logic        sleep_o;

  modport master (
    output id_loadstall_i, id_inst_invalid_i, id_pc_invalid_i, id_wfi_i, id_pc_i,
    output ex_branch_i, ex_target_i, mem_busy_i, irq_i,
    input  stall_o, flush_o, redirect_o, redirect_pc_o, epc_o, cause_o, sleep_o
  );

  modport slave (
    input  id_loadstall_i, id_inst_invalid_i, id_pc_invalid_i, id_wfi_i, id_pc_i,
    input  ex_branch_i, ex_target_i, mem_busy_i, irq_i,
    output stall_o, flush_o, redirect_o, redirect_pc_o, epc_o, cause_o, sleep_o
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//------------------------------------------------------------------------------
// pipe_ctrl : stall/flush/redirect generation, trap bookkeeping and WFI sleep
//             sequencing for the 5-stage RV32 pipeline.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int          DRAIN_CYC = 3
) (
  input  wire         clk,
  input  wire         rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {RUN, TRAP, DRAIN, SLEEP} state_t;

  state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0] epc, epc_nxt;
  logic [1:0]  cause, cause_nxt;
  logic        sleep;
  logic [5:0]  stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      epc   <= '0;
      cause <= 2'b00;
      sleep <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      epc   <= epc_nxt;
      cause <= cause_nxt;
      sleep <= (state_nxt == SLEEP);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    epc_nxt     = epc;
    cause_nxt   = cause;
    stall       = 6'b000000;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = RESET_PC;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (bus.mem_busy_i) begin
            stall = 6'b111111;
          end else if (bus.ex_branch_i) begin
            // ID holds a wrong-path instruction; its events are dropped
            flush       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = bus.ex_target_i;
          end else if (bus.id_pc_invalid_i || bus.id_inst_invalid_i) begin
            flush     = 1'b1;
            stall[0]  = 1'b1;
            epc_nxt   = bus.id_pc_i;
            cause_nxt = bus.id_pc_invalid_i ? 2'b10 : 2'b01;
            state_nxt = TRAP;
          end else if (bus.id_wfi_i) begin
            flush     = 1'b1;
            stall     = 6'b000011;
            epc_nxt   = bus.id_pc_i + 32'd4;
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else if (bus.id_loadstall_i) begin
            stall = 6'b000111;
          end
        end
        TRAP: begin
          flush       = 1'b1;
          redirect    = 1'b1;
          redirect_pc = TRAP_VEC;
          state_nxt   = RUN;
        end
        DRAIN: begin
          flush = 1'b1;
          if (bus.mem_busy_i) begin
            stall = 6'b111111;
          end else begin
            stall   = 6'b000011;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state_nxt = SLEEP;
          end
        end
        SLEEP: begin
          stall = 6'b111111;
          if (bus.irq_i) begin
            cause_nxt = 2'b11;
            state_nxt = TRAP;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign bus.stall_o       = stall;
  assign bus.flush_o       = flush;
  assign bus.redirect_o    = redirect;
  assign bus.redirect_pc_o = redirect_pc;
  assign bus.epc_o         = epc;
  assign bus.cause_o       = cause;
  assign bus.sleep_o       = sleep;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipe_ctrl : table-driven scoreboard bench for pipe_ctrl plus a WFI/irq
//                latency sequence.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0100),
    .DRAIN_CYC (3)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ctl bits: [7] rst_n [6] busy [5] branch [4] pc_inv [3] inst_inv [2] wfi [1] loadstall [0] irq
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [5:0]  stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        sleep;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(logic [7:0] ctl, logic [31:0] pc, logic [31:0] tgt,
                              logic [5:0] st, logic fl, logic rd, logic [31:0] rpc,
                              logic [31:0] epc, logic [1:0] cause, logic slp);
    vec_t v;
    v.ctl = ctl; v.pc = pc; v.tgt = tgt; v.stall = st; v.flush = fl; v.redir = rd;
    v.rpc = rpc; v.epc = epc; v.cause = cause; v.sleep = slp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n                 = v.ctl[7];
    bus.mem_busy_i        = v.ctl[6];
    bus.ex_branch_i       = v.ctl[5];
    bus.id_pc_invalid_i   = v.ctl[4];
    bus.id_inst_invalid_i = v.ctl[3];
    bus.id_wfi_i          = v.ctl[2];
    bus.id_loadstall_i    = v.ctl[1];
    bus.irq_i             = v.ctl[0];
    bus.id_pc_i           = v.pc;
    bus.ex_target_i       = v.tgt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    int   cycles;

    // Reset with every input asserted
    vecs.push_back(mk(8'h7F, 32'hFFFF_FFFC, 32'h40, 6'h00, 0, 0, 32'h0,   32'h0,    2'd0, 0));
    vecs.push_back(mk(8'h7F, 32'hFFFF_FFFC, 32'h40, 6'h00, 0, 0, 32'h0,   32'h0,    2'd0, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h00, 0, 0, 32'h0,   32'h0,    2'd0, 0));
    // Load-use stall, one cycle only; branch overrides it
    vecs.push_back(mk(8'h82, 32'h8,    32'h0,  6'h07, 0, 0, 32'h0,   32'h0,    2'd0, 0));
    vecs.push_back(mk(8'h80, 32'h8,    32'h0,  6'h00, 0, 0, 32'h0,   32'h0,    2'd0, 0));
    vecs.push_back(mk(8'hA2, 32'h8,    32'h40, 6'h00, 1, 1, 32'h40,  32'h0,    2'd0, 0));
    // Branch discards a simultaneous illegal instruction
    vecs.push_back(mk(8'hA8, 32'h1C,   32'h80, 6'h00, 1, 1, 32'h80,  32'h0,    2'd0, 0));
    vecs.push_back(mk(8'h80, 32'h1C,   32'h0,  6'h00, 0, 0, 32'h0,   32'h0,    2'd0, 0));
    // Illegal instruction trap; TRAP ignores busy and load stall
    vecs.push_back(mk(8'h88, 32'h1C,   32'h0,  6'h01, 1, 0, 32'h0,   32'h1C,   2'd1, 0));
    vecs.push_back(mk(8'hC2, 32'h1C,   32'h0,  6'h00, 1, 1, 32'h100, 32'h1C,   2'd1, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h00, 0, 0, 32'h0,   32'h1C,   2'd1, 0));
    // Busy blocks a fetch fault until it drops
    vecs.push_back(mk(8'hD0, 32'h2000, 32'h0,  6'h3F, 0, 0, 32'h0,   32'h1C,   2'd1, 0));
    vecs.push_back(mk(8'hD0, 32'h2000, 32'h0,  6'h3F, 0, 0, 32'h0,   32'h1C,   2'd1, 0));
    vecs.push_back(mk(8'h90, 32'h2000, 32'h0,  6'h01, 1, 0, 32'h0,   32'h2000, 2'd2, 0));
    vecs.push_back(mk(8'h81, 32'h0,    32'h0,  6'h00, 1, 1, 32'h100, 32'h2000, 2'd2, 0));
    // Fetch fault outranks illegal instruction
    vecs.push_back(mk(8'h98, 32'h44,   32'h0,  6'h01, 1, 0, 32'h0,   32'h44,   2'd2, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h00, 1, 1, 32'h100, 32'h44,   2'd2, 0));
    // WFI at top of address space, two busy cycles in DRAIN, then irq
    vecs.push_back(mk(8'h84, 32'hFFFF_FFFC, 32'h0, 6'h03, 1, 0, 32'h0, 32'h0,  2'd2, 0));
    vecs.push_back(mk(8'h81, 32'h0,    32'h0,  6'h03, 1, 0, 32'h0,   32'h0,    2'd2, 0));
    vecs.push_back(mk(8'hC0, 32'h0,    32'h0,  6'h3F, 1, 0, 32'h0,   32'h0,    2'd2, 0));
    vecs.push_back(mk(8'hC0, 32'h0,    32'h0,  6'h3F, 1, 0, 32'h0,   32'h0,    2'd2, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h03, 1, 0, 32'h0,   32'h0,    2'd2, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h03, 1, 0, 32'h0,   32'h0,    2'd2, 1));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h3F, 0, 0, 32'h0,   32'h0,    2'd2, 1));
    vecs.push_back(mk(8'h81, 32'h0,    32'h0,  6'h3F, 0, 0, 32'h0,   32'h0,    2'd3, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h00, 1, 1, 32'h100, 32'h0,    2'd3, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h00, 0, 0, 32'h0,   32'h0,    2'd3, 0));
    // Sleep again, then reset while sleeping
    vecs.push_back(mk(8'h84, 32'h10,   32'h0,  6'h03, 1, 0, 32'h0,   32'h14,   2'd3, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h03, 1, 0, 32'h0,   32'h14,   2'd3, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h03, 1, 0, 32'h0,   32'h14,   2'd3, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h03, 1, 0, 32'h0,   32'h14,   2'd3, 1));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h3F, 0, 0, 32'h0,   32'h14,   2'd3, 1));
    vecs.push_back(mk(8'h00, 32'h0,    32'h0,  6'h00, 0, 0, 32'h0,   32'h0,    2'd0, 0));
    vecs.push_back(mk(8'h80, 32'h0,    32'h0,  6'h00, 0, 0, 32'h0,   32'h0,    2'd0, 0));

    drive(mk(8'h00, 32'h0, 32'h0, 6'h00, 0, 0, 32'h0, 32'h0, 2'd0, 0));
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.stall_o !== e.stall || bus.flush_o !== e.flush ||
          bus.redirect_o !== e.redir || bus.redirect_pc_o !== e.rpc) begin
        errors++;
        $display("FAIL comb[%0d]: got stall=%b flush=%b redir=%b pc=%h expected stall=%b flush=%b redir=%b pc=%h",
                 i, bus.stall_o, bus.flush_o, bus.redirect_o, bus.redirect_pc_o,
                 e.stall, e.flush, e.redir, e.rpc);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.epc_o !== e.epc || bus.cause_o !== e.cause || bus.sleep_o !== e.sleep) begin
        errors++;
        $display("FAIL reg[%0d]: got epc=%h cause=%b sleep=%b expected epc=%h cause=%b sleep=%b",
                 i, bus.epc_o, bus.cause_o, bus.sleep_o, e.epc, e.cause, e.sleep);
      end
    end

    // WFI-to-sleep latency with a bounded wait, then irq wake-up
    drive(mk(8'h84, 32'h200, 32'h0, 6'h00, 0, 0, 32'h0, 32'h0, 2'd0, 0));
    @(posedge clk);
    #1;
    drive(mk(8'h80, 32'h0, 32'h0, 6'h00, 0, 0, 32'h0, 32'h0, 2'd0, 0));
    cycles = 1;
    while (!bus.sleep_o && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("wfi_latency", 32'(cycles), 32'd4);
    chk("wfi_epc", bus.epc_o, 32'h204);
    bus.irq_i = 1'b1;
    @(negedge clk);
    chk("sleep_stall", {26'd0, bus.stall_o}, 32'h3F);
    chk("sleep_no_redir", {31'd0, bus.redirect_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.irq_i = 1'b0;
    chk("wake_sleep", {31'd0, bus.sleep_o}, 32'd0);
    chk("wake_cause", {30'd0, bus.cause_o}, 32'd3);
    chk("wake_redir", {31'd0, bus.redirect_o}, 32'd1);
    chk("wake_pc", bus.redirect_pc_o, 32'h100);
    @(posedge clk);
    #1;
    chk("back_to_run", {31'd0, bus.redirect_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage RV32 core. Collects hazard and event indications from decode (load-use stall, illegal instruction, fetch fault, WFI), from execute (taken branch/jump), from data memory (busy) and from the interrupt line. Produces the per-stage stall vector, the IF/ID + ID/EX flush, the PC redirect, and the trap bookkeeping (EPC, cause). Sits beside the pipeline registers and the PC unit; owns the WFI sleep sequence.

## Interface
- RESET_PC, 32'h0000_0000, value driven on redirect_pc_o when idle/reset
- TRAP_VEC, 32'h0000_0100, handler address for all traps
- DRAIN_CYC, 3, non-busy cycles needed to retire EX/MEM/WB before sleep
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- id_loadstall_i  in  1  load-use hazard on the ID instruction
- id_inst_invalid_i  in  1  ID instruction is illegal
- id_pc_invalid_i  in  1  ID instruction carries a fetch fault
- id_wfi_i  in  1  ID instruction is WFI
- id_pc_i  in  32  PC of the ID instruction
- ex_branch_i  in  1  EX resolved a taken branch/JAL
- ex_target_i  in  32  branch/jump target
- mem_busy_i  in  1  data memory not ready
- irq_i  in  1  level interrupt, honoured only in SLEEP
- stall_o  out  6  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB; 1 = hold
- flush_o  out  1  clear IF/ID and ID/EX (insert bubbles)
- redirect_o  out  1  PC loads redirect_pc_o next edge
- redirect_pc_o  out  32  redirect target
- epc_o  out  32  registered trap/return PC
- cause_o  out  2  registered: 00 none, 01 illegal, 10 fetch fault, 11 interrupt
- sleep_o  out  1  core halted in WFI

## Operation
- States: RUN, TRAP, DRAIN, SLEEP. Reset state RUN.
- stall_o, flush_o, redirect_o, redirect_pc_o are combinational from state and inputs; all forced to 0 / RESET_PC while rst_n = 0. Defaults: stall 0, flush 0, redirect 0, redirect_pc = RESET_PC.
- RUN, priority highest first:
  - mem_busy_i: stall_o = 6'b111111; nothing else acts, no state change.
  - ex_branch_i: flush_o = 1, redirect_o = 1, redirect_pc_o = ex_target_i. ID-side events that cycle are discarded (wrong path).
  - id_pc_invalid_i: flush_o = 1, stall_o[0] = 1; epc <= id_pc_i, cause <= 10; -> TRAP.
  - id_inst_invalid_i: same, cause <= 01.
  - id_wfi_i: flush_o = 1, stall_o[1:0] = 2'b11; epc <= id_pc_i + 4 (mod 2^32); cause unchanged; counter <= 0; -> DRAIN.
  - id_loadstall_i: stall_o = 6'b000111 (EX receives bubble).
- TRAP (1 cycle): flush_o = 1, redirect_o = 1, redirect_pc_o = TRAP_VEC; -> RUN. mem_busy_i ignored (front-end only).
- DRAIN: stall_o = 6'b000011, flush_o = 1. Counter increments on cycles with mem_busy_i = 0; while busy, stall_o = 6'b111111 and counter holds. When counter reaches DRAIN_CYC-1 on a non-busy cycle -> SLEEP.
- SLEEP: stall_o = 6'b111111, sleep_o = 1. irq_i = 1: cause <= 11, epc unchanged (PC after WFI) -> TRAP.
- irq_i ignored in RUN, TRAP, DRAIN.
- epc_o, cause_o held until overwritten; reset to 0 / 00. sleep_o registered decode of state == SLEEP; reset 0.
- rst_n low in any state: next edge state RUN, counter 0, epc 0, cause 00.

## Timing
- Load-use and branch responses act in the same cycle as the request (zero latency).
- Illegal/fetch fault detected cycle N: flush at N; TRAP at N+1 with redirect to TRAP_VEC; RUN at N+2.
- WFI in ID at cycle N: flush at N; DRAIN N+1..N+3 (no busy); sleep_o = 1 from N+4.
- irq_i high at cycle M in SLEEP: TRAP at M+1 (redirect), RUN at M+2, sleep_o = 0 from M+1.
- Each mem_busy_i cycle in DRAIN extends SLEEP entry by one cycle.

## Test plan
- Reset: rst_n = 0 for 2 cycles with all inputs 1 -> stall_o 0, flush 0, redirect 0, redirect_pc 0, epc 0, cause 00, sleep 0.
- id_loadstall_i = 1 one cycle -> stall_o = 6'b000111 that cycle only; with ex_branch_i = 1, target 0x40 simultaneously -> flush 1, redirect to 0x40, stall_o 0.
- id_inst_invalid_i at id_pc_i = 0x1C -> flush cycle N; N+1 redirect 0x100; epc 0x1C, cause 01.
- mem_busy_i = 1 with id_pc_invalid_i = 1 -> stall_o 6'b111111, no trap; busy drops -> trap, cause 10.
- WFI at pc 0xFFFF_FFFC, mem_busy_i high 2 cycles in DRAIN -> epc 0x0, sleep_o at N+6; irq_i pulse -> redirect 0x100, cause 11, sleep_o 0.
- rst_n low during SLEEP -> next edge state RUN, sleep_o 0, stall_o 0, epc 0.
